// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: captures ALU results and MEM/WB controls behind a
// valid/ready handshake, owns the architectural flag register and raises overflow traps.
module ex_mem_stage #(
    parameter int                REG_AW            = 5,
    parameter int                FLAG_W            = 32,
    parameter int                FLAG_BIT_ZERO     = 0,
    parameter int                FLAG_BIT_OVERFLOW = 1,
    parameter logic [FLAG_W-1:0] FLAG_RESET        = {FLAG_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       alu_out,
    input  logic [FLAG_W-1:0] nflag,
    input  logic [31:0]       store_data,
    input  logic [REG_AW-1:0] dst,
    input  logic              reg_we,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic              flag_we,
    input  logic              trap_ovf,
    input  logic              flag_clr,
    input  logic              flush,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [31:0]       out_alu,
    output logic [31:0]       out_store,
    output logic [REG_AW-1:0] out_dst,
    output logic              out_reg_we,
    output logic              out_mem_rd,
    output logic              out_mem_wr,
    output logic [FLAG_W-1:0] flag_q,
    output logic              exc_ovf
);

    if (FLAG_BIT_ZERO >= FLAG_W || FLAG_BIT_OVERFLOW >= FLAG_W ||
        FLAG_BIT_ZERO == FLAG_BIT_OVERFLOW) begin : g_bad_flag_bits
        $error("ex_mem_stage: flag bit indices out of range or overlapping");
    end

    logic              r_valid;
    logic [31:0]       r_alu;
    logic [31:0]       r_store;
    logic [REG_AW-1:0] r_dst;
    logic              r_reg_we;
    logic              r_mem_rd;
    logic              r_mem_wr;
    logic [FLAG_W-1:0] r_flag;
    logic              r_exc;

    logic w_in_ready;
    logic w_accept;
    logic w_ovf;

    // Handshake and trap decode; only a freshly raised overflow bit traps.
    always_comb begin
        w_in_ready = !r_valid || out_ready;
        w_accept   = in_valid && w_in_ready && !flush;
        w_ovf      = trap_ovf && nflag[FLAG_BIT_OVERFLOW] && !r_flag[FLAG_BIT_OVERFLOW];
    end

    // Pipeline payload register: flush > accept > drain > hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_alu    <= 32'd0;
            r_store  <= 32'd0;
            r_dst    <= {REG_AW{1'b0}};
            r_reg_we <= 1'b0;
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid  <= 1'b1;
            r_alu    <= alu_out;
            r_store  <= store_data;
            r_dst    <= dst;
            r_reg_we <= reg_we && !w_ovf;
            r_mem_rd <= mem_rd;
            r_mem_wr <= mem_wr && !w_ovf;
        end else if (out_ready && r_valid) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_valid;
        end
    end

    // Architectural flags; a clear on the same edge beats the commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flag <= FLAG_RESET;
        end else if (flag_clr) begin
            r_flag <= FLAG_RESET;
        end else if (w_accept && flag_we) begin
            r_flag <= nflag;
        end else begin
            r_flag <= r_flag;
        end
    end

    // Exception pulse lasts exactly the cycle after the trapping accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exc <= 1'b0;
        end else begin
            r_exc <= w_accept && w_ovf;
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = r_valid;
    assign out_alu    = r_alu;
    assign out_store  = r_store;
    assign out_dst    = r_dst;
    assign out_reg_we = r_reg_we;
    assign out_mem_rd = r_mem_rd;
    assign out_mem_wr = r_mem_wr;
    assign flag_q     = r_flag;
    assign exc_ovf    = r_exc;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed scenarios plus random traffic
// compared against a queue-based transaction model.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] alu_out, nflag, store_data;
    logic [4:0]  dst;
    logic        reg_we, mem_rd, mem_wr, flag_we, trap_ovf, flag_clr, flush, out_ready;
    logic        out_valid, out_reg_we, out_mem_rd, out_mem_wr, exc_ovf;
    logic [31:0] out_alu, out_store, flag_q;
    logic [4:0]  out_dst;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] st;
        logic [4:0]  dst;
        logic        we;
        logic        rd;
        logic        wr;
    } txn_t;

    // Reference model: the stage holds at most one transaction.
    txn_t        slot_q[$];
    logic [31:0] m_flag = 32'd0;
    logic        m_exc  = 1'b0;
    logic        s_in_ready;
    logic        m_rdy;

    ex_mem_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_out(alu_out), .nflag(nflag), .store_data(store_data), .dst(dst),
        .reg_we(reg_we), .mem_rd(mem_rd), .mem_wr(mem_wr), .flag_we(flag_we),
        .trap_ovf(trap_ovf), .flag_clr(flag_clr), .flush(flush), .out_ready(out_ready),
        .out_valid(out_valid), .out_alu(out_alu), .out_store(out_store), .out_dst(out_dst),
        .out_reg_we(out_reg_we), .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr),
        .flag_q(flag_q), .exc_ovf(exc_ovf)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        in_valid = 1'b0; alu_out = 32'd0; nflag = 32'd0; store_data = 32'd0; dst = 5'd0;
        reg_we = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; flag_we = 1'b0; trap_ovf = 1'b0;
        flag_clr = 1'b0; flush = 1'b0; out_ready = 1'b1;
    endtask

    task automatic model_reset();
        slot_q.delete();
        m_flag = 32'd0;
        m_exc  = 1'b0;
    endtask

    // One clock: sample in_ready before the edge, advance the model, settle after it.
    task automatic cycle();
        logic        acc, trap, do_flush, do_drain;
        logic [31:0] n_flag;
        txn_t        t;
        #1;
        s_in_ready = in_ready;
        m_rdy    = (slot_q.size() == 0) || out_ready;
        acc      = in_valid && m_rdy && !flush;
        trap     = trap_ovf && nflag[1] && !m_flag[1];
        do_flush = flush;
        do_drain = out_ready && (slot_q.size() != 0);
        t.alu = alu_out; t.st = store_data; t.dst = dst;
        t.we = reg_we && !trap; t.rd = mem_rd; t.wr = mem_wr && !trap;
        n_flag = flag_clr ? 32'd0 : ((acc && flag_we) ? nflag : m_flag);
        @(posedge clk);
        #1;
        if (do_flush) slot_q.delete();
        else if (acc) begin
            if (slot_q.size() != 0) void'(slot_q.pop_front());
            slot_q.push_back(t);
        end else if (do_drain) void'(slot_q.pop_front());
        m_exc  = acc && trap;
        m_flag = n_flag;
    endtask

    task automatic test_reset();
        vectors++; if (out_valid !== 1'b0 || exc_ovf !== 1'b0 || flag_q !== 32'd0 || out_alu !== 32'd0) begin
            miscompares++; $display("FAIL reset_state valid=%0b exc=%0b flag=%h alu=%h want 0", out_valid, exc_ovf, flag_q, out_alu); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        idle_inputs();
        in_valid = 1'b1; alu_out = 32'h55; reg_we = 1'b1; mem_rd = 1'b1; dst = 5'd3;
        flag_we = 1'b1; nflag = 32'h3; out_ready = 1'b0;
        cycle();
        vectors++; if (out_valid !== 1'b1 || flag_q !== 32'h3) begin
            miscompares++; $display("FAIL pre_reset valid=%0b flag=%h want 1/3", out_valid, flag_q); end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        vectors++; if (out_valid !== 1'b0 || out_reg_we !== 1'b0 || out_mem_rd !== 1'b0 || out_mem_wr !== 1'b0 ||
                       exc_ovf !== 1'b0 || out_alu !== 32'd0 || out_store !== 32'd0 || out_dst !== 5'd0 || flag_q !== 32'd0) begin
            miscompares++; $display("FAIL async_reset valid=%0b we=%0b rd=%0b alu=%h dst=%0d flag=%h want all 0",
                                     out_valid, out_reg_we, out_mem_rd, out_alu, out_dst, flag_q); end
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        in_valid = 1'b1; alu_out = 32'h1234;
        cycle();
        vectors++; if (out_valid !== 1'b1 || out_alu !== 32'h1234) begin
            miscompares++; $display("FAIL first_accept valid=%0b alu=%h want 1/1234", out_valid, out_alu); end
        idle_inputs();
        cycle();
    endtask

    task automatic test_stall();
        idle_inputs();
        in_valid = 1'b1; alu_out = 32'hA;
        cycle();
        vectors++; if (out_alu !== 32'hA || out_valid !== 1'b1) begin
            miscompares++; $display("FAIL stall_load alu=%h valid=%0b want A/1", out_alu, out_valid); end
        out_ready = 1'b0; alu_out = 32'hB;
        for (int i = 0; i < 3; i++) begin
            cycle();
            vectors++; if (s_in_ready !== 1'b0) begin miscompares++; $display("FAIL stall_in_ready got %0b want 0", s_in_ready); end
            vectors++; if (out_alu !== 32'hA || out_valid !== 1'b1) begin
                miscompares++; $display("FAIL stall_hold alu=%h valid=%0b want A/1", out_alu, out_valid); end
        end
        out_ready = 1'b1;
        cycle();
        vectors++; if (out_alu !== 32'hB || out_valid !== 1'b1) begin
            miscompares++; $display("FAIL stall_release alu=%h valid=%0b want B/1", out_alu, out_valid); end
        in_valid = 1'b0;
        cycle();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL stall_drain valid=%0b want 0", out_valid); end
    endtask

    task automatic test_overflow();
        idle_inputs();
        flag_clr = 1'b1;
        cycle();
        idle_inputs();
        in_valid = 1'b1; trap_ovf = 1'b1; nflag = 32'h2; flag_we = 1'b1; reg_we = 1'b1; mem_wr = 1'b1; dst = 5'd8;
        cycle();
        vectors++; if (out_valid !== 1'b1 || out_reg_we !== 1'b0 || out_mem_wr !== 1'b0 || exc_ovf !== 1'b1 || flag_q !== 32'h2) begin
            miscompares++; $display("FAIL ovf_trap valid=%0b we=%0b wr=%0b exc=%0b flag=%h want 1/0/0/1/2",
                                     out_valid, out_reg_we, out_mem_wr, exc_ovf, flag_q); end
        vectors++; if (out_dst !== 5'd8) begin miscompares++; $display("FAIL ovf_dst got %0d want 8", out_dst); end
        in_valid = 1'b0;
        cycle();
        vectors++; if (exc_ovf !== 1'b0) begin miscompares++; $display("FAIL ovf_pulse_width exc=%0b want 0", exc_ovf); end
        in_valid = 1'b1; trap_ovf = 1'b0;
        cycle();
        vectors++; if (out_reg_we !== 1'b1 || out_mem_wr !== 1'b1 || exc_ovf !== 1'b0) begin
            miscompares++; $display("FAIL ovf_notrap we=%0b wr=%0b exc=%0b want 1/1/0", out_reg_we, out_mem_wr, exc_ovf); end
        trap_ovf = 1'b1;
        cycle();
        vectors++; if (out_reg_we !== 1'b1 || exc_ovf !== 1'b0) begin
            miscompares++; $display("FAIL ovf_sticky we=%0b exc=%0b want 1/0", out_reg_we, exc_ovf); end
        idle_inputs();
        cycle();
    endtask

    task automatic test_flush();
        idle_inputs();
        flag_clr = 1'b1;
        cycle();
        idle_inputs();
        in_valid = 1'b1; flag_we = 1'b1; nflag = 32'h1; flush = 1'b1;
        cycle();
        vectors++; if (s_in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_in_ready got %0b want 1", s_in_ready); end
        vectors++; if (out_valid !== 1'b0 || flag_q !== 32'd0) begin
            miscompares++; $display("FAIL flush_accept valid=%0b flag=%h want 0/0", out_valid, flag_q); end
        flush = 1'b0; flag_we = 1'b0; out_ready = 1'b0; alu_out = 32'h77;
        cycle();
        in_valid = 1'b0; flush = 1'b1;
        cycle();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_held valid=%0b want 0", out_valid); end
        idle_inputs();
    endtask

    task automatic test_flag_priority();
        idle_inputs();
        in_valid = 1'b1; flag_we = 1'b1; nflag = 32'h3; flag_clr = 1'b1;
        cycle();
        vectors++; if (flag_q !== 32'd0) begin miscompares++; $display("FAIL flag_clr_wins got %h want 0", flag_q); end
        flag_clr = 1'b0; nflag = 32'h1;
        cycle();
        vectors++; if (flag_q !== 32'h1) begin miscompares++; $display("FAIL flag_commit got %h want 1", flag_q); end
        idle_inputs();
        cycle();
    endtask

    task automatic test_back_to_back();
        idle_inputs();
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; alu_out = 32'(i);
            cycle();
            vectors++; if (s_in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_in_ready[%0d] got %0b want 1", i, s_in_ready); end
            vectors++; if (out_valid !== 1'b1 || out_alu !== 32'(i)) begin
                miscompares++; $display("FAIL b2b_data[%0d] valid=%0b alu=%h want 1/%h", i, out_valid, out_alu, i); end
        end
        idle_inputs();
        cycle();
    endtask

    task automatic test_random();
        txn_t e;
        for (int n = 0; n < 400; n++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            alu_out    = $urandom();
            store_data = $urandom();
            dst        = 5'($urandom());
            nflag      = 32'($urandom_range(0, 3));
            reg_we     = 1'($urandom()); mem_rd = 1'($urandom()); mem_wr = 1'($urandom());
            flag_we    = 1'($urandom()); trap_ovf = 1'($urandom());
            flag_clr   = ($urandom_range(0, 9) == 0);
            flush      = ($urandom_range(0, 11) == 0);
            out_ready  = ($urandom_range(0, 2) != 0);
            cycle();
            vectors++; if (s_in_ready !== m_rdy) begin miscompares++; $display("FAIL rnd_in_ready[%0d] got %0b want %0b", n, s_in_ready, m_rdy); end
            vectors++; if (out_valid !== (slot_q.size() != 0)) begin
                miscompares++; $display("FAIL rnd_valid[%0d] got %0b want %0b", n, out_valid, slot_q.size() != 0); end
            vectors++; if (flag_q !== m_flag || exc_ovf !== m_exc) begin
                miscompares++; $display("FAIL rnd_flag_exc[%0d] flag=%h exc=%0b want %h/%0b", n, flag_q, exc_ovf, m_flag, m_exc); end
            if (slot_q.size() != 0) begin
                e = slot_q[0];
                vectors++; if (out_alu !== e.alu || out_store !== e.st || out_dst !== e.dst ||
                               out_reg_we !== e.we || out_mem_rd !== e.rd || out_mem_wr !== e.wr) begin
                    miscompares++; $display("FAIL rnd_payload[%0d] alu=%h st=%h dst=%0d we/rd/wr=%0b%0b%0b want %h %h %0d %0b%0b%0b",
                        n, out_alu, out_store, out_dst, out_reg_we, out_mem_rd, out_mem_wr, e.alu, e.st, e.dst, e.we, e.rd, e.wr); end
            end
        end
        idle_inputs();
        cycle();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        #12 rst_n = 1'b1;
        test_reset();
        test_stall();
        test_overflow();
        test_flush();
        test_flag_priority();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
